// File: rtl/rename_map_table.sv
// N-wide register rename map with per-branch checkpoints.
// Restores from a snapshot on mispredict or from the back RAT on flush.
module rename_map_table #(
    parameter int ARCH_REGS    = 32,
    parameter int PHY_WIDTH    = 6,
    parameter int RENAME_WIDTH = 2,
    parameter int NUM_CKPT     = 4,
    parameter int CKPT_W       = $clog2(NUM_CKPT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [PHY_WIDTH*ARCH_REGS-1:0]    back_rat,
    input  logic [RENAME_WIDTH-1:0]           rename_valid,
    output logic                              rename_ready,
    input  logic [5*RENAME_WIDTH-1:0]         rs1_arch,
    input  logic [5*RENAME_WIDTH-1:0]         rs2_arch,
    input  logic [5*RENAME_WIDTH-1:0]         rd_arch,
    input  logic [PHY_WIDTH*RENAME_WIDTH-1:0] rd_phy_new,
    input  logic [RENAME_WIDTH-1:0]           ckpt_req,
    output logic [PHY_WIDTH*RENAME_WIDTH-1:0] rs1_phy,
    output logic [PHY_WIDTH*RENAME_WIDTH-1:0] rs2_phy,
    output logic [PHY_WIDTH*RENAME_WIDTH-1:0] rd_phy_old,
    output logic [CKPT_W*RENAME_WIDTH-1:0]    ckpt_id,
    output logic                              ckpt_full,
    input  logic                              restore_valid,
    input  logic [CKPT_W-1:0]                 restore_id,
    input  logic                              release_valid,
    output logic [CKPT_W:0]                   ckpt_count
);

    localparam int AW = 5;
    localparam int PW = PHY_WIDTH;
    localparam int RW = RENAME_WIDTH;
    localparam int CW = CKPT_W;

    typedef logic [PW-1:0] tag_t;

    tag_t          map_q  [ARCH_REGS];
    tag_t          snap_q [NUM_CKPT][ARCH_REGS];
    tag_t          stage  [RW][ARCH_REGS];
    logic [CW-1:0] sid    [RW];
    logic [AW-1:0] rs1_a  [RW];
    logic [AW-1:0] rs2_a  [RW];
    logic [AW-1:0] rd_a   [RW];
    tag_t          new_t  [RW];

    logic [CW-1:0] head_q;
    logic [CW-1:0] tail_q;
    logic [CW:0]   count_q;
    logic [CW:0]   nreq;
    logic [CW+1:0] free_cnt;
    logic          rel;
    logic          accept;
    logic [CW-1:0] head_nx;
    logic [CW-1:0] rdist;

    // Unpack the per-slot fields of the flat port vectors.
    always_comb begin
        for (int k = 0; k < RW; k++) begin
            rs1_a[k] = rs1_arch[k*AW +: AW];
            rs2_a[k] = rs2_arch[k*AW +: AW];
            rd_a[k]  = rd_arch[k*AW +: AW];
            new_t[k] = rd_phy_new[k*PW +: PW];
        end
    end

    // Source and old-dest lookup with bypass from older slots of the group.
    always_comb begin : lookup
        tag_t t1;
        tag_t t2;
        tag_t to;
        rs1_phy    = '0;
        rs2_phy    = '0;
        rd_phy_old = '0;
        for (int k = 0; k < RW; k++) begin
            t1 = map_q[rs1_a[k]];
            t2 = map_q[rs2_a[k]];
            to = map_q[rd_a[k]];
            for (int j = 0; j < k; j++) begin
                if (rename_valid[j] && rd_a[j] != '0) begin
                    if (rd_a[j] == rs1_a[k]) t1 = new_t[j];
                    if (rd_a[j] == rs2_a[k]) t2 = new_t[j];
                    if (rd_a[j] == rd_a[k])  to = new_t[j];
                end
            end
            if (rs1_a[k] == '0) t1 = '0;
            if (rs2_a[k] == '0) t2 = '0;
            if (rd_a[k] == '0)  to = '0;
            rs1_phy[k*PW +: PW]    = t1;
            rs2_phy[k*PW +: PW]    = t2;
            rd_phy_old[k*PW +: PW] = to;
        end
    end

    // Map as seen after each slot, plus checkpoint id assignment.
    always_comb begin : staging
        tag_t          cur [ARCH_REGS];
        logic [CW-1:0] id;
        cur     = map_q;
        id      = tail_q;
        nreq    = '0;
        ckpt_id = '0;
        for (int k = 0; k < RW; k++) begin
            if (rename_valid[k] && rd_a[k] != '0) begin
                cur[rd_a[k]] = new_t[k];
            end
            stage[k]               = cur;
            sid[k]                 = id;
            ckpt_id[k*CW +: CW]    = id;
            if (rename_valid[k] && ckpt_req[k]) begin
                id   = id + 1'b1;
                nreq = nreq + 1'b1;
            end
        end
    end

    // Acceptance: whole group or nothing, gated by free checkpoints.
    always_comb begin
        rel      = release_valid && (count_q != '0);
        free_cnt = (CW+2)'(NUM_CKPT) - {1'b0, count_q}
                 + {{(CW+1){1'b0}}, rel};
        rename_ready = !flush && !restore_valid
                     && (free_cnt >= {1'b0, nreq});
        accept   = rename_ready;
        head_nx  = head_q + {{(CW-1){1'b0}}, rel};
        rdist    = restore_id - head_nx;
    end

    assign ckpt_count = count_q;
    assign ckpt_full  = (count_q == (CW+1)'(NUM_CKPT));

    // Map and checkpoint FIFO pointers: flush > restore > rename.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= tag_t'(i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= back_rat[i*PW +: PW] & {PW{i != 0}};
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (restore_valid) begin
            map_q   <= snap_q[restore_id];
            head_q  <= head_nx;
            tail_q  <= restore_id + 1'b1;
            count_q <= {1'b0, rdist} + 1'b1;
        end else begin
            head_q <= head_nx;
            if (accept) begin
                map_q   <= stage[RW-1];
                tail_q  <= tail_q + nreq[CW-1:0];
                count_q <= count_q - {{CW{1'b0}}, rel} + nreq;
            end else begin
                count_q <= count_q - {{CW{1'b0}}, rel};
            end
        end
    end

    // Snapshot storage needs no reset; only live entries are ever read.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < RW; k++) begin
                if (rename_valid[k] && ckpt_req[k]) begin
                    snap_q[sid[k]] <= stage[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table with a sequential rename model
// checked every cycle, plus literal expectations from hand calculation.
module tb_rename_map_table;

    localparam int AR = 32;
    localparam int PW = 6;
    localparam int RW = 2;
    localparam int NC = 4;
    localparam int CW = 2;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [PW*AR-1:0]  back_rat;
    logic [RW-1:0]     rename_valid;
    logic              rename_ready;
    logic [5*RW-1:0]   rs1_arch;
    logic [5*RW-1:0]   rs2_arch;
    logic [5*RW-1:0]   rd_arch;
    logic [PW*RW-1:0]  rd_phy_new;
    logic [RW-1:0]     ckpt_req;
    logic [PW*RW-1:0]  rs1_phy;
    logic [PW*RW-1:0]  rs2_phy;
    logic [PW*RW-1:0]  rd_phy_old;
    logic [CW*RW-1:0]  ckpt_id;
    logic              ckpt_full;
    logic              restore_valid;
    logic [CW-1:0]     restore_id;
    logic              release_valid;
    logic [CW:0]       ckpt_count;

    int errors = 0;
    int checks = 0;

    int mmap [AR];
    int msnap [NC][AR];
    int mhead, mtail, mcount;

    rename_map_table #(
        .ARCH_REGS(AR), .PHY_WIDTH(PW), .RENAME_WIDTH(RW), .NUM_CKPT(NC)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .back_rat(back_rat),
        .rename_valid(rename_valid), .rename_ready(rename_ready),
        .rs1_arch(rs1_arch), .rs2_arch(rs2_arch), .rd_arch(rd_arch),
        .rd_phy_new(rd_phy_new), .ckpt_req(ckpt_req),
        .rs1_phy(rs1_phy), .rs2_phy(rs2_phy), .rd_phy_old(rd_phy_old),
        .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
        .restore_valid(restore_valid), .restore_id(restore_id),
        .release_valid(release_valid), .ckpt_count(ckpt_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int f_rs1(input int k);
        return int'(rs1_arch[k*5 +: 5]);
    endfunction
    function automatic int f_rs2(input int k);
        return int'(rs2_arch[k*5 +: 5]);
    endfunction
    function automatic int f_rd(input int k);
        return int'(rd_arch[k*5 +: 5]);
    endfunction
    function automatic int f_new(input int k);
        return int'(rd_phy_new[k*PW +: PW]);
    endfunction
    function automatic int n_req();
        int n = 0;
        for (int k = 0; k < RW; k++)
            if (rename_valid[k] && ckpt_req[k]) n++;
        return n;
    endfunction
    function automatic bit m_ready();
        return !flush && !restore_valid
            && ((NC - mcount + int'(release_valid)) >= n_req());
    endfunction

    // Model: instructions renamed one after another against a plain map.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < AR; i++) mmap[i] = i;
            mhead = 0; mtail = 0; mcount = 0;
        end else if (flush) begin
            for (int i = 0; i < AR; i++)
                mmap[i] = (i == 0) ? 0 : int'(back_rat[i*PW +: PW]);
            mhead = 0; mtail = 0; mcount = 0;
        end else begin
            bit ok;
            bit rl;
            ok = m_ready();
            rl = release_valid && mcount > 0;
            if (restore_valid) begin
                if (rl) mhead = (mhead + 1) % NC;
                mmap   = msnap[restore_id];
                mtail  = (int'(restore_id) + 1) % NC;
                mcount = ((int'(restore_id) - mhead + NC) % NC) + 1;
            end else begin
                if (rl) begin
                    mhead = (mhead + 1) % NC;
                    mcount--;
                end
                if (ok) begin
                    for (int k = 0; k < RW; k++) begin
                        if (rename_valid[k] && f_rd(k) != 0)
                            mmap[f_rd(k)] = f_new(k);
                        if (rename_valid[k] && ckpt_req[k]) begin
                            msnap[mtail] = mmap;
                            mtail = (mtail + 1) % NC;
                            mcount++;
                        end
                    end
                end
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            int tmp [AR];
            int nr;
            tmp = mmap;
            nr  = 0;
            for (int k = 0; k < RW; k++) begin
                chk("rs1_phy", int'(rs1_phy[k*PW +: PW]),
                    f_rs1(k) == 0 ? 0 : tmp[f_rs1(k)]);
                chk("rs2_phy", int'(rs2_phy[k*PW +: PW]),
                    f_rs2(k) == 0 ? 0 : tmp[f_rs2(k)]);
                chk("rd_phy_old", int'(rd_phy_old[k*PW +: PW]),
                    f_rd(k) == 0 ? 0 : tmp[f_rd(k)]);
                chk("ckpt_id", int'(ckpt_id[k*CW +: CW]), (mtail + nr) % NC);
                if (rename_valid[k] && ckpt_req[k]) nr++;
                if (rename_valid[k] && f_rd(k) != 0) tmp[f_rd(k)] = f_new(k);
            end
            chk("rename_ready", int'(rename_ready), int'(m_ready()));
            chk("ckpt_count", int'(ckpt_count), mcount);
            chk("ckpt_full", int'(ckpt_full), int'(mcount == NC));
            if (restore_valid && !flush)
                chk("restore_live",
                    int'(((int'(restore_id) - mhead + NC) % NC) < mcount), 1);
        end
    end

    task automatic clr();
        flush = 0; rename_valid = '0; rs1_arch = '0; rs2_arch = '0;
        rd_arch = '0; rd_phy_new = '0; ckpt_req = '0;
        restore_valid = 0; restore_id = '0; release_valid = 0;
    endtask

    task automatic slot(input int k, input bit v, input int r1, input int r2,
                        input int rd, input int nw, input bit rq);
        rename_valid[k]       = v;
        rs1_arch[k*5 +: 5]    = 5'(r1);
        rs2_arch[k*5 +: 5]    = 5'(r2);
        rd_arch[k*5 +: 5]     = 5'(rd);
        rd_phy_new[k*PW +: PW] = PW'(nw);
        ckpt_req[k]           = rq;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int s1(input int k);
        return int'(rs1_phy[k*PW +: PW]);
    endfunction
    function automatic int s2(input int k);
        return int'(rs2_phy[k*PW +: PW]);
    endfunction
    function automatic int od(input int k);
        return int'(rd_phy_old[k*PW +: PW]);
    endfunction
    function automatic int ci(input int k);
        return int'(ckpt_id[k*CW +: CW]);
    endfunction

    initial begin
        rst = 1;
        clr();
        for (int i = 0; i < AR; i++) back_rat[i*PW +: PW] = PW'(i + 32);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // identity map after reset
        slot(0, 0, 5, 0, 0, 0, 0);
        #1;
        chk("lit_reset_rs1", s1(0), 5);
        chk("lit_reset_count", int'(ckpt_count), 0);
        chk("lit_reset_full", int'(ckpt_full), 0);
        tick();

        // intra-group bypass and same-rd collision
        clr();
        slot(0, 1, 0, 0, 3, 40, 0);
        slot(1, 1, 3, 0, 3, 41, 0);
        #1;
        chk("lit_byp_rs1", s1(1), 40);
        chk("lit_byp_old1", od(1), 40);
        chk("lit_byp_old0", od(0), 3);
        chk("lit_byp_ready", int'(rename_ready), 1);
        tick();
        clr();
        slot(0, 0, 3, 0, 0, 0, 0);
        #1 chk("lit_map3", s1(0), 41);
        tick();

        // x0 never written, never bypassed
        clr();
        slot(0, 1, 0, 0, 0, 50, 0);
        slot(1, 1, 0, 0, 0, 0, 0);
        #1 chk("lit_x0_rs2", s2(1), 0);
        tick();
        clr();
        #1 chk("lit_x0_rs1", s1(0), 0);
        tick();

        // move tail to 3, then drain
        clr();
        slot(0, 1, 0, 0, 1, 10, 1);
        tick();
        clr();
        slot(0, 1, 0, 0, 2, 11, 1);
        slot(1, 1, 0, 0, 4, 12, 1);
        #1;
        chk("lit_id_a", ci(0), 1);
        chk("lit_id_b", ci(1), 2);
        tick();
        clr();
        #1 chk("lit_cnt3", int'(ckpt_count), 3);
        release_valid = 1;
        tick(); tick(); tick();
        clr();
        #1 chk("lit_cnt0", int'(ckpt_count), 0);

        // two checkpoints wrapping the id
        slot(0, 1, 0, 0, 7, 33, 1);
        slot(1, 1, 0, 0, 7, 34, 1);
        #1;
        chk("lit_wrap_id0", ci(0), 3);
        chk("lit_wrap_id1", ci(1), 0);
        tick();
        clr();
        slot(0, 0, 7, 0, 0, 0, 0);
        #1;
        chk("lit_map7", s1(0), 34);
        chk("lit_cnt2", int'(ckpt_count), 2);

        // fill, stall, then stall relieved by release
        slot(0, 1, 0, 0, 8, 35, 1);
        slot(1, 1, 0, 0, 9, 36, 1);
        #1;
        chk("lit_fill_id0", ci(0), 1);
        chk("lit_fill_id1", ci(1), 2);
        tick();
        clr();
        #1;
        chk("lit_cnt4", int'(ckpt_count), 4);
        chk("lit_full", int'(ckpt_full), 1);
        slot(0, 1, 0, 0, 10, 37, 1);
        #1 chk("lit_stall", int'(rename_ready), 0);
        release_valid = 1;
        #1 chk("lit_unstall", int'(rename_ready), 1);
        tick();
        clr();
        #1 chk("lit_cnt4b", int'(ckpt_count), 4);

        // release one, leaving ids 1,2,3; restore the middle one
        release_valid = 1;
        tick();
        clr();
        #1 chk("lit_cnt3b", int'(ckpt_count), 3);
        restore_valid = 1;
        restore_id = 2'd2;
        slot(0, 1, 9, 10, 0, 0, 0);
        #1 chk("lit_restore_ready", int'(rename_ready), 0);
        tick();
        clr();
        slot(0, 0, 9, 10, 0, 0, 0);
        slot(1, 0, 8, 7, 0, 0, 0);
        #1;
        chk("lit_rst_map9", s1(0), 36);
        chk("lit_rst_map10", s2(0), 10);
        chk("lit_rst_map8", s1(1), 35);
        chk("lit_rst_map7", s2(1), 34);
        chk("lit_rst_cnt", int'(ckpt_count), 2);
        tick();
        clr();
        slot(0, 1, 0, 0, 11, 38, 1);
        #1 chk("lit_reuse_id", ci(0), 3);
        tick();
        clr();
        #1 chk("lit_cnt3c", int'(ckpt_count), 3);

        // flush beats simultaneous restore and release
        flush = 1;
        release_valid = 1;
        restore_valid = 1;
        restore_id = 2'd2;
        #1 chk("lit_flush_ready", int'(rename_ready), 0);
        tick();
        clr();
        slot(0, 0, 4, 0, 0, 0, 0);
        slot(1, 0, 11, 0, 0, 0, 0);
        #1;
        chk("lit_flush_map4", s1(0), 36);
        chk("lit_flush_map11", s1(1), 43);
        chk("lit_flush_cnt", int'(ckpt_count), 0);
        tick();

        // asynchronous reset mid-cycle
        clr();
        slot(0, 1, 0, 0, 3, 20, 1);
        tick();
        clr();
        slot(0, 0, 3, 0, 0, 0, 0);
        #1 chk("lit_pre_rst", s1(0), 20);
        #1 rst = 1;
        #1;
        chk("lit_arst_map3", s1(0), 3);
        chk("lit_arst_cnt", int'(ckpt_count), 0);
        #2 rst = 0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rename_map_table.md
Name: rename_map_table

Overview:
- Parametrised, N-wide front-end register rename map with branch checkpointing.
- Each cycle it maps up to RENAME_WIDTH instructions' sources and destinations to physical tags, and resolves dependencies inside the rename group.
- It snapshots the whole map for each branch, and restores from a snapshot on a mispredict or from the committed map on a full flush.
- It sits between decode and dispatch, fed by the free list, and receives the committed map from the back RAT.

Parameters:
- ARCH_REGS, 32, number of architectural registers; index 0 is hardwired zero.
- PHY_WIDTH, 6, physical tag width.
- RENAME_WIDTH, 2, instructions renamed per cycle (slot 0 is oldest).
- NUM_CKPT, 4, checkpoint slots; power of two, at least 2.
- CKPT_W, $clog2(NUM_CKPT), checkpoint id width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  restore map from back_rat and discard all checkpoints
- back_rat  in  PHY_WIDTH*ARCH_REGS  committed map; entry i is at [i*PHY_WIDTH +: PHY_WIDTH]
- rename_valid  in  RENAME_WIDTH  per-slot instruction valid
- rename_ready  out  1  group accepted this cycle
- rs1_arch, rs2_arch, rd_arch  in  5*RENAME_WIDTH each  per-slot architectural registers
- rd_phy_new  in  PHY_WIDTH*RENAME_WIDTH  tag allocated by the free list per slot
- ckpt_req  in  RENAME_WIDTH  slot is a branch and needs a snapshot
- rs1_phy, rs2_phy  out  PHY_WIDTH*RENAME_WIDTH  mapped source tags
- rd_phy_old  out  PHY_WIDTH*RENAME_WIDTH  previous mapping of rd, freed at commit
- ckpt_id  out  CKPT_W*RENAME_WIDTH  checkpoint assigned to the slot
- ckpt_full  out  1  no checkpoint free
- restore_valid  in  1  branch mispredict recovery
- restore_id  in  CKPT_W  checkpoint to restore
- release_valid  in  1  oldest checkpoint's branch resolved correct; free it
- ckpt_count  out  CKPT_W+1  live checkpoints

Behaviour:
- Reset (async):
  - map[i] = i.
  - Checkpoint head = tail = 0, ckpt_count = 0, ckpt_full = 0.
  - Snapshot storage contents are don't-care.
- Lookup is combinational, in the same cycle:
  - Slot k source r, r != 0: takes rd_phy_new of the youngest slot j<k with rename_valid[j], rd_arch[j]==r and rd_arch[j]!=0. If no such slot exists, it takes map[r].
  - rd_phy_old[k] uses the same bypass rule, applied to rd_arch[k].
  - Any arch index 0 yields tag 0 and is never written.
  - Outputs are valid regardless of rename_ready; consumers gate them with rename_ready & rename_valid.
- Acceptance:
  - rename_ready = !flush & !restore_valid & (free checkpoints >= popcount(rename_valid & ckpt_req)).
  - free checkpoints = NUM_CKPT - ckpt_count + release_valid.
  - A group is accepted whole or not at all; no partial groups.
- Update at posedge, when accepted:
  - For each valid slot in order 0..N-1, with rd != 0: map[rd] <= rd_phy_new. On a rd collision the youngest slot wins.
- Checkpoints form a circular FIFO:
  - Each accepted slot with ckpt_req gets id = tail + (count of earlier requesting slots in the group), mod NUM_CKPT.
  - Its snapshot is the map after applying that slot and all older slots of the group. Younger slots are excluded.
  - tail advances by the number of requests.
- Release: release_valid frees the checkpoint at head; head++ and count--. Release while count==0 is ignored.
- Restore:
  - map <= snap[restore_id]; tail <= restore_id+1.
  - count <= (restore_id - head) mod NUM_CKPT + 1, which keeps the restored checkpoint live. A simultaneous release is applied first.
  - Younger checkpoints are discarded. No rename occurs that cycle.
  - A restore_id outside the live range is undefined; the bench asserts it never happens.
- Flush: map <= back_rat (entry 0 forced to 0), head = tail = count = 0. Any release or restore in the same cycle is ignored.
- Priority: rst > flush > restore > rename. release combines with rename and with restore.
- ckpt_full = (ckpt_count == NUM_CKPT). Wrap-around of head/tail is natural modulo NUM_CKPT.
- Reset mid-operation: all pending state is discarded immediately, and the map returns to identity.

Test Plan:
- Reset, no traffic: rs1_arch[0]=5 -> rs1_phy[0]=5; ckpt_count=0, ckpt_full=0.
- Slot0 rd=3 new=40; slot1 rs1=3, rd=3 new=41 -> rs1_phy[1]=40, rd_phy_old[1]=40, rd_phy_old[0]=3; next cycle map[3]=41.
- Slot0 rd=0 new=50, slot1 rs2=0 -> rs2_phy[1]=0; map[0] stays 0.
- Two-slot group, both ckpt_req, with slot0 rd=7 new=33 and slot1 rd=7 new=34, at tail=3 -> ckpt_id 3 and 0 (wrap); snap[3] has map[7]=33, snap[0] has map[7]=34; count+2.
- Fill all 4 checkpoints, then present a group with ckpt_req -> rename_ready=0. Assert release_valid in the same cycle -> rename_ready=1 and count stays 4.
- With 3 live checkpoints, restore_id = the middle one -> map equals that snapshot, count=2, and the next allocation reuses the id after it. Then flush with back_rat[i]=i+32 -> map[4]=36, map[0]=0, count=0.
